// File: rtl/reg_dump_reader.sv
// reg_dump_reader: debug read-out engine for the core's register file.
// On start it stalls the core, walks idx from first_reg to last_reg through
// a dedicated register-file read port, and streams each value out on a
// valid/ready channel tagged with its index. Two cycles per word: FETCH
// captures the combinational read, SEND holds it until accepted.
module reg_dump_reader #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int ZERO_X0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              core_stall,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] lim_q, lim_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              idx_is_zero;
    logic              at_last;

    assign idx_is_zero = (idx_q == '0);
    assign at_last     = (idx_q == lim_q);

    // Next-state logic: range capture, fetch/send walk and reject pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_reg <= last_reg) begin
                        state_d = S_SETTLE;
                        idx_d   = first_reg;
                        lim_d   = last_reg;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Stall is already up; let any write committed at entry land.
            S_SETTLE: state_d = S_FETCH;
            S_FETCH: begin
                data_d  = ((ZERO_X0 != 0) && idx_is_zero) ? '0 : rf_rdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        // idx < lim here, so the increment cannot wrap.
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; async reset abandons any dump in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lim_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from registered state so reset drops them at once.
    assign busy       = (state_q != S_IDLE);
    assign core_stall = busy;
    assign rf_raddr   = busy ? idx_q : '0;
    assign out_valid  = (state_q == S_SEND);
    assign out_data   = data_q;
    assign out_index  = idx_q;
    assign out_last   = (state_q == S_SEND) && at_last;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader: register file modelled as an array, expected
// stream built from the requested range, observed stream recorded per cycle.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg, last_reg;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        core_stall, busy, out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last, done, err;

    logic [31:0] rf [32];
    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .ZERO_X0(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_reg(first_reg), .last_reg(last_reg),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .core_stall(core_stall), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .done(done), .err(err)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t got[$];
    word_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    busy_cnt, done_cnt, done_cyc, err_cnt, err_cyc, hold_viol, stall_cycles, valid_cnt;

    // Reference: a dump of f..l yields one word per register, x0 reads as 0.
    task automatic build_exp(input int f, input int l);
        word_t w;
        exp_q.delete();
        for (int i = f; i <= l; i++) begin
            w.idx  = 5'(i);
            w.data = (i == 0) ? 32'h0 : rf[i];
            w.last = (i == l);
            exp_q.push_back(w);
        end
    endtask

    // Issues one start and records what the DUT does for up to max_cyc cycles.
    // rmode: 0 ready always, 1 random ready, 2 stall stall_len cycles on stall_idx.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int rmode,
                            input int stall_idx, input int stall_len, input bit extra_start,
                            input int max_cyc);
        logic [31:0] hd;
        logic [4:0]  hi;
        bit          holding;
        int          stall_left;
        word_t       w;
        got.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        hold_viol = 0; stall_cycles = 0; valid_cnt = 0;
        holding = 0; stall_left = stall_len; hd = '0; hi = '0;
        @(negedge clk);
        first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (extra_start && cyc == 5) begin
                start = 1'b1; first_reg = 5'd4; last_reg = 5'd31;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_index == 5'(stall_idx) && stall_left > 0) begin
                        out_ready = 1'b0; stall_left--;
                    end else out_ready = 1'b1;
                end
            endcase
            #1;
            if (busy) busy_cnt++;
            if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (out_valid) begin
                valid_cnt++;
                if (holding && (out_data !== hd || out_index !== hi)) hold_viol++;
                if (out_ready) begin
                    w.idx = out_index; w.data = out_data; w.last = out_last;
                    got.push_back(w);
                    holding = 0;
                end else begin
                    holding = 1; hd = out_data; hi = out_index; stall_cycles++;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", core_stall); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if ({out_last, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_last, done, err}); end
        total++; if (rf_raddr !== 5'd0 || out_index !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d/%0d want=0/0", rf_raddr, out_index); end
        total++; if (out_data !== 32'h0)  begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        for (int k = 0; k < 32; k++) rf[k] = 32'h1000 + k;
        build_exp(0, 31);
        run_dump(5'd0, 5'd31, 0, 0, 0, 1'b0, 120);
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].idx !== exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL full_word%0d got=%0d:%h:%b want=%0d:%h:%b", i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
        total++; if (done_cyc != 65) begin bad++; $display("FAIL full_done_cyc got=%0d want=65", done_cyc); end
        total++; if (busy_cnt != 66) begin bad++; $display("FAIL full_busy got=%0d want=66", busy_cnt); end
        total++; if (done_cnt != 1)  begin bad++; $display("FAIL full_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_single();
        rf[7] = 32'hDEADBEEF;
        run_dump(5'd7, 5'd7, 0, 0, 0, 1'b0, 20);
        total++;
        if (got.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", got.size()); end
        else if (got[0].idx !== 5'd7 || got[0].data !== 32'hDEADBEEF || got[0].last !== 1'b1) begin
            bad++; $display("FAIL single_word got=%0d:%h:%b want=7:deadbeef:1", got[0].idx, got[0].data, got[0].last);
        end
        total++; if (done_cyc != 3) begin bad++; $display("FAIL single_done_cyc got=%0d want=3", done_cyc); end
        total++; if (busy_cnt != 4) begin bad++; $display("FAIL single_busy got=%0d want=4", busy_cnt); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        build_exp(3, 5);
        run_dump(5'd3, 5'd5, 2, 4, 5, 1'b0, 40);
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].idx !== exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                bad++; $display("FAIL bp_word%0d got=%0d:%h want=%0d:%h", i, got[i].idx, got[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        total++; if (stall_cycles != 5) begin bad++; $display("FAIL bp_stalls got=%0d want=5", stall_cycles); end
        total++; if (hold_viol != 0)    begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_viol); end
        total++; if (busy_cnt != 13)    begin bad++; $display("FAIL bp_busy got=%0d want=13", busy_cnt); end
    endtask

    task automatic test_illegal();
        run_dump(5'd9, 5'd2, 0, 0, 0, 1'b0, 6);
        total++; if (err_cnt != 1 || err_cyc != 0) begin bad++; $display("FAIL illegal_err got=%0d@%0d want=1@0", err_cnt, err_cyc); end
        total++; if (busy_cnt != 0)  begin bad++; $display("FAIL illegal_busy got=%0d want=0", busy_cnt); end
        total++; if (valid_cnt != 0) begin bad++; $display("FAIL illegal_valid got=%0d want=0", valid_cnt); end
        total++; if (done_cnt != 0)  begin bad++; $display("FAIL illegal_done got=%0d want=0", done_cnt); end
    endtask

    task automatic test_start_busy();
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        build_exp(0, 31);
        run_dump(5'd0, 5'd31, 0, 0, 0, 1'b1, 120);
        total++; if (got.size() != 32) begin bad++; $display("FAIL sb_count got=%0d want=32", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].idx !== exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                bad++; $display("FAIL sb_word%0d got=%0d:%h want=%0d:%h", i, got[i].idx, got[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL sb_done_cnt got=%0d want=1", done_cnt); end
        total++; if (err_cnt != 0)  begin bad++; $display("FAIL sb_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int dn;
        found = 0; dn = 0;
        @(negedge clk);
        first_reg = 5'd0; last_reg = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_index == 5'd10) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rm_reach got=0 want=1"); end
        #2 reset = 1'b1;
        #1;
        total++; if ({out_valid, core_stall, busy} !== 3'b000) begin bad++; $display("FAIL rm_async got=%b want=000", {out_valid, core_stall, busy}); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL rm_quiet got=%0d want=0", dn); end
        build_exp(0, 1);
        run_dump(5'd0, 5'd1, 0, 0, 0, 1'b0, 20);
        total++; if (got.size() != 2) begin bad++; $display("FAIL rm_count got=%0d want=2", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].idx !== exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                bad++; $display("FAIL rm_word%0d got=%0d:%h:%b want=%0d:%h:%b", i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rm_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_random();
        int f, l, n;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 32; k++) rf[k] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(f, 31);
            n = l - f + 1;
            build_exp(f, l);
            run_dump(5'(f), 5'(l), 1, 0, 0, 1'b0, 500);
            total++; if (got.size() != n) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, got.size(), n); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                total++;
                if (got[i].idx !== exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                    bad++; $display("FAIL rnd%0d_word%0d got=%0d:%h:%b want=%0d:%h:%b", it, i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
                end
            end
            total++; if (busy_cnt != 2 * n + 2 + stall_cycles) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", it, busy_cnt, 2 * n + 2 + stall_cycles); end
            total++; if (hold_viol != 0) begin bad++; $display("FAIL rnd%0d_hold got=%0d want=0", it, hold_viol); end
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = '0;
        test_reset();
        test_full_dump();
        test_single();
        test_backpressure();
        test_illegal();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
